hdb_cmd_rx: RTL and testbench
=============================

Name: hdb_cmd_rx

Overview:
Upstream front end of the debug controller. It takes the raw host-debug byte stream from the host link and frames it into complete commands: one command character plus a little-endian integer argument, presented on a valid/ready handshake. It synthesises the 0xFF "read timeout" command when the host is silent while debug control is engaged, so the controller's NOP path behaves the same in hardware as in simulation.

Parameters:
TIMEOUT_CYCLES, 1000, idle clock cycles (with ctrlen=1) before a timeout event; legal range >= 2
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter (derived; not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
ctrlen  input  1  debug controller holds the CPU; timeouts are counted only while high
in_data  input  8  byte from host link
in_valid  input  1  in_data valid
in_ready  output  1  byte accepted when in_valid && in_ready
cmd  output  8  command character; 0xFF means timeout
arg  output  32  zero-extended little-endian argument
cmd_valid  output  1  cmd/arg valid
cmd_ready  input  1  consumer takes the command when cmd_valid && cmd_ready
abort  output  1  one-cycle pulse: partial argument discarded on timeout

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, cmd=0, arg=0, cmd_valid=0, abort=0, timeout counter=0. in_ready=1 once rst_n is high.
- Argument byte count by command: 'A'=2, 'B'=1, 'O'=4, 'M'=4, 'r'=4. All other characters, including unknown ones and 0xFF, take 0 bytes and pass through unchanged.
- States:
  - IDLE: in_ready=1.
    - Byte accepted with count 0: latch cmd, set arg=0, go to HOLD, with cmd_valid=1 on the next cycle.
    - Byte accepted with count N>0: latch cmd, clear arg, set remaining=N, go to ARG.
  - ARG: in_ready=1.
    - The k-th accepted byte (k=0..N-1) is written to arg[8k+7:8k].
    - When remaining reaches 0, go to HOLD.
  - HOLD: in_ready=0 and cmd_valid=1.
    - cmd and arg stay stable until cmd_ready is sampled high, then go to IDLE.
    - cmd_valid drops on the cycle after the handshake.
- Latency:
  - A zero-argument command gives cmd_valid 1 cycle after byte acceptance.
  - An N-byte argument gives cmd_valid 1 cycle after the last argument byte.
  - At most one command is outstanding; there is no queueing.
- Timeout counter:
  - Counts in IDLE and ARG only, and only while ctrlen=1 and no byte is accepted that cycle.
  - Cleared on any accepted byte, on state entry, and whenever ctrlen=0.
  - IDLE, counter reaches TIMEOUT_CYCLES: emit cmd=0xFF, arg=0, go to HOLD.
  - ARG, counter reaches TIMEOUT_CYCLES: pulse abort for 1 cycle, discard the partial cmd/arg (cmd_valid never asserts), go to IDLE.
- Simultaneous events:
  - A byte accepted in the same cycle the counter would expire wins; the counter clears and no timeout occurs.
  - ctrlen falling while in ARG does not abort the frame; the frame completes normally.
  - A handshake in HOLD plus in_valid in the same cycle: the byte is not accepted (in_ready=0). It is taken in IDLE on the next cycle.
- Reset mid-frame: the partial command is dropped, all outputs return to their reset values, and cmd_valid is never seen for that frame.
- 0xFF received from the host is treated as an ordinary zero-argument command, indistinguishable from a timeout.

Decomposition:
- Shared include hdb.vinc, used by this block and the debug controller:
  - command character constants (HDB_CMD_A, _B, _O, _M, _R, _TIMEOUT=8'hFF);
  - arg-length function, 8-bit char to 3-bit count.
- Sub-module hdb_timeout_ctr:
  - parameterised saturating counter with clear/enable and an "expired" output;
  - instantiated once.
- The frame FSM stays in hdb_cmd_rx.

Test Plan:
1. Bytes 'A', 0x34, 0x12 back-to-back, cmd_ready=1 -> one cmd_valid cycle 1 cycle after 0x12 with cmd='A', arg=0x00001234.
2. Byte 'M', then 0x78, 0x56, 0x34, 0x12 with random in_valid gaps (< TIMEOUT), cmd_ready held 0 for 5 cycles -> arg=0x12345678 stable across the stall, in_ready=0 throughout HOLD, single handshake.
3. ctrlen=1 and no input for TIMEOUT_CYCLES=8 -> cmd=0xFF, arg=0 valid; ctrlen=0 for 100 cycles -> no cmd_valid.
4. 'O', 0xAA, then silence for 8 cycles -> abort pulses exactly 1 cycle, no cmd_valid; next 'c' gives cmd='c', arg=0.
5. rst_n asserted between the 2nd and 3rd byte of 'r' -> outputs reset immediately; after release, 'R' produces cmd='R', arg=0 with no stale bytes.
6. Byte accepted exactly on the expiry cycle in ARG ('B' then 0x5A at cycle 8) -> no abort; cmd='B', arg=0x5A.

Source files
------------

// File: rtl/hdb_cmd_rx_pkg.sv
// Shared host-debug command definitions: command characters and argument lengths.
package hdb_cmd_rx_pkg;

    localparam logic [7:0] HDB_CMD_A       = 8'h41;  // 'A'
    localparam logic [7:0] HDB_CMD_B       = 8'h42;  // 'B'
    localparam logic [7:0] HDB_CMD_O       = 8'h4F;  // 'O'
    localparam logic [7:0] HDB_CMD_M       = 8'h4D;  // 'M'
    localparam logic [7:0] HDB_CMD_R       = 8'h72;  // 'r'
    localparam logic [7:0] HDB_CMD_TIMEOUT = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARG,
        ST_HOLD
    } rx_state_e;

    function automatic logic [2:0] hdb_arg_len(input logic [7:0] c);
        logic [2:0] n;
        case (c)
            HDB_CMD_A: n = 3'd2;
            HDB_CMD_B: n = 3'd1;
            HDB_CMD_O,
            HDB_CMD_M,
            HDB_CMD_R: n = 3'd4;
            default:   n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/hdb_cmd_rx_timeout_ctr.sv
// Saturating idle counter; expired_o flags the cycle that completes TIMEOUT_CYCLES idle cycles.
module hdb_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Independent of clr_i so the caller may clear on its own state change without a loop.
    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/hdb_cmd_rx.sv
// Frames the host-debug byte stream into command + little-endian argument on a valid/ready
// handshake, synthesising the 0xFF timeout command while debug control is engaged.
module hdb_cmd_rx
    import hdb_cmd_rx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ctrlen,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  cmd,
    output logic [31:0] arg,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        abort
);

    rx_state_e   state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [31:0] arg_q, arg_d;
    logic [2:0]  len_q, len_d;
    logic [1:0]  idx_q, idx_d;
    logic        abort_q, abort_d;
    logic        acc, tmo_clr, tmo_en, tmo;

    assign in_ready = (state_q != ST_HOLD);
    assign acc      = in_valid && in_ready;

    // An accepted byte always beats an expiring counter; ctrlen low or any state change resets it.
    assign tmo_en  = ctrlen && !acc && (state_q != ST_HOLD);
    assign tmo_clr = acc || !ctrlen || (state_q == ST_HOLD) || (state_d != state_q);

    hdb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_tmo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (tmo_clr),
        .en_i      (tmo_en),
        .expired_o (tmo)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        arg_d   = arg_q;
        len_d   = len_q;
        idx_d   = idx_q;
        abort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    cmd_d   = in_data;
                    arg_d   = '0;
                    idx_d   = '0;
                    len_d   = hdb_arg_len(in_data);
                    state_d = (hdb_arg_len(in_data) == 3'd0) ? ST_HOLD : ST_ARG;
                end else if (tmo) begin
                    cmd_d   = HDB_CMD_TIMEOUT;
                    arg_d   = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_ARG: begin
                if (acc) begin
                    arg_d = arg_q | (32'(in_data) << {idx_q, 3'b000});
                    idx_d = idx_q + 2'd1;
                    if (({1'b0, idx_q} + 3'd1) == len_q) begin
                        state_d = ST_HOLD;
                    end
                end else if (tmo) begin
                    abort_d = 1'b1;
                    cmd_d   = '0;
                    arg_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cmd_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            arg_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            arg_q   <= arg_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            abort_q <= abort_d;
        end
    end

    assign cmd       = cmd_q;
    assign arg       = arg_q;
    assign cmd_valid = (state_q == ST_HOLD);
    assign abort     = abort_q;

endmodule

// File: tb/tb_hdb_cmd_rx.sv
// Directed and randomized checks of hdb_cmd_rx against a byte-level framing model.
module tb_hdb_cmd_rx;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ctrlen = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        cmd_ready = 1'b0;
    logic        in_ready, cmd_valid, abort;
    logic [7:0]  cmd;
    logic [31:0] arg;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hdb_cmd_rx #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctrlen    (ctrlen),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cmd       (cmd),
        .arg       (arg),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .abort     (abort)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("byte_accepted", 32'(done), 32'd1);
    endtask

    // Argument length table of the host-debug protocol.
    function automatic int ref_len(input logic [7:0] c);
        case (c)
            "A":               return 2;
            "B":               return 1;
            "O", "M", "r":     return 4;
            default:           return 0;
        endcase
    endfunction

    initial begin
        logic [7:0]  c;
        logic [31:0] val, expv;
        logic [63:0] mask;
        logic [7:0]  tbl [6];
        int          n, seen;

        tbl[0] = "A"; tbl[1] = "B"; tbl[2] = "O"; tbl[3] = "M"; tbl[4] = "r"; tbl[5] = "c";

        // Reset state
        step(2);
        chk("rst_cmd", 32'(cmd), 32'h0);
        chk("rst_arg", arg, 32'h0);
        chk("rst_valid", 32'(cmd_valid), 32'h0);
        chk("rst_abort", 32'(abort), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        ctrlen = 1'b1;

        // 1: 'A' 0x34 0x12 back-to-back, consumer always ready
        cmd_ready = 1'b1;
        send_byte("A");
        send_byte(8'h34);
        send_byte(8'h12);
        chk("t1_valid", 32'(cmd_valid), 32'h1);
        chk("t1_cmd", 32'(cmd), 32'h41);
        chk("t1_arg", arg, 32'h0000_1234);
        step(1);
        chk("t1_single", 32'(cmd_valid), 32'h0);

        // 2: 'M' with random gaps, stalled consumer, then handshake with a pending byte
        cmd_ready = 1'b0;
        send_byte("M");
        val = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            step($urandom_range(0, 5));
            send_byte(8'(val >> (8 * k)));
        end
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 32'(cmd_valid), 32'h1);
            chk("t2_hold_ready", 32'(in_ready), 32'h0);
            chk("t2_hold_arg", arg, 32'h1234_5678);
            chk("t2_hold_cmd", 32'(cmd), 32'h4D);
            step(1);
        end
        cmd_ready = 1'b1;
        in_data   = 8'h63;
        in_valid  = 1'b1;
        step(1);
        chk("t2_hs_drop", 32'(cmd_valid), 32'h0);
        chk("t2_idle_ready", 32'(in_ready), 32'h1);
        step(1);
        in_valid = 1'b0;
        chk("t2_next_valid", 32'(cmd_valid), 32'h1);
        chk("t2_next_cmd", 32'(cmd), 32'h63);
        chk("t2_next_arg", arg, 32'h0);
        step(1);
        chk("t2_next_drop", 32'(cmd_valid), 32'h0);

        // 3: idle timeout, then no timeouts with ctrlen low
        cmd_ready = 1'b0;
        step(TMO - 1);
        chk("t3_not_yet", 32'(cmd_valid), 32'h0);
        step(1);
        chk("t3_tmo_valid", 32'(cmd_valid), 32'h1);
        chk("t3_tmo_cmd", 32'(cmd), 32'hFF);
        chk("t3_tmo_arg", arg, 32'h0);
        cmd_ready = 1'b1;
        step(1);
        chk("t3_tmo_drop", 32'(cmd_valid), 32'h0);
        ctrlen    = 1'b0;
        cmd_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (cmd_valid) seen++;
        end
        chk("t3_ctrlen_off", 32'(seen), 32'h0);
        ctrlen = 1'b1;

        // 4: partial frame abandoned by timeout
        send_byte("O");
        send_byte(8'hAA);
        step(TMO - 1);
        chk("t4_abort_early", 32'(abort), 32'h0);
        step(1);
        chk("t4_abort", 32'(abort), 32'h1);
        chk("t4_no_valid", 32'(cmd_valid), 32'h0);
        step(1);
        chk("t4_abort_pulse", 32'(abort), 32'h0);
        chk("t4_no_valid2", 32'(cmd_valid), 32'h0);
        send_byte("c");
        chk("t4_c_valid", 32'(cmd_valid), 32'h1);
        chk("t4_c_cmd", 32'(cmd), 32'h63);
        chk("t4_c_arg", arg, 32'h0);
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;

        // 5: reset mid-frame
        send_byte("r");
        send_byte(8'h11);
        send_byte(8'h22);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_cmd", 32'(cmd), 32'h0);
        chk("t5_rst_arg", arg, 32'h0);
        chk("t5_rst_valid", 32'(cmd_valid), 32'h0);
        step(3);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_post_valid", 32'(cmd_valid), 32'h0);
        send_byte("R");
        chk("t5_R_valid", 32'(cmd_valid), 32'h1);
        chk("t5_R_cmd", 32'(cmd), 32'h52);
        chk("t5_R_arg", arg, 32'h0);
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;

        // 6: argument byte lands on the would-be expiry cycle
        send_byte("B");
        step(TMO - 1);
        send_byte(8'h5A);
        chk("t6_no_abort", 32'(abort), 32'h0);
        chk("t6_valid", 32'(cmd_valid), 32'h1);
        chk("t6_cmd", 32'(cmd), 32'h42);
        chk("t6_arg", arg, 32'h0000_005A);
        cmd_ready = 1'b1;
        step(1);
        chk("t6_drop", 32'(cmd_valid), 32'h0);
        cmd_ready = 1'b0;

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            n = $urandom_range(0, 6);
            c = (n == 6) ? 8'($urandom_range(0, 255)) : tbl[n];
            val    = $urandom;
            n      = ref_len(c);
            mask   = (64'd1 << (8 * n)) - 64'd1;
            expv   = val & mask[31:0];
            ctrlen = 1'($urandom_range(0, 1));
            step($urandom_range(0, 4));
            send_byte(c);
            for (int k = 0; k < n; k++) begin
                step($urandom_range(0, 5));
                send_byte(8'(val >> (8 * k)));
            end
            chk("rnd_valid", 32'(cmd_valid), 32'h1);
            chk("rnd_cmd", 32'(cmd), 32'(c));
            chk("rnd_arg", arg, expv);
            repeat ($urandom_range(0, 3)) begin
                step(1);
                chk("rnd_stall_arg", arg, expv);
            end
            cmd_ready = 1'b1;
            step(1);
            chk("rnd_drop", 32'(cmd_valid), 32'h0);
            cmd_ready = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
